grf_scoreboard: RTL and testbench

- Per-register issue scheduler in front of the 32x32 GRF, which has one write port and same-cycle write-to-read bypass.
- Tracks the cycles remaining until each in-flight destination register is written.
- Reserves the single write-port slot for each in-flight write.
- Gates instruction issue on RAW, WAW and write-port conflicts.
- Sits between decode (issue request) and the pipeline stall logic.

---
 rtl/grf_scoreboard_if.sv | 31 +++
 rtl/grf_scoreboard.sv | 82 ++++++++
 tb/tb_grf_scoreboard.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/grf_scoreboard_if.sv
// rtl/grf_scoreboard_if.sv - Issue request / hazard status bundle between decode and the GRF scoreboard
interface grf_scoreboard_if #(
    parameter int NREG  = 32,
    parameter int CNT_W = 3
);
    localparam int RW = $clog2(NREG);

    logic             issue_valid;
    logic [RW-1:0]    issue_dst;
    logic [CNT_W-1:0] issue_lat;
    logic [RW-1:0]    rs_a;
    logic [RW-1:0]    rs_b;
    logic             need_a;
    logic             need_b;
    logic             issue_ready;
    logic             stall_raw;
    logic             stall_waw;
    logic             stall_port;
    logic [NREG-1:0]  busy_mask;
    logic             wb_due;

    modport master (
        output issue_valid, issue_dst, issue_lat, rs_a, rs_b, need_a, need_b,
        input  issue_ready, stall_raw, stall_waw, stall_port, busy_mask, wb_due
    );

    modport slave (
        input  issue_valid, issue_dst, issue_lat, rs_a, rs_b, need_a, need_b,
        output issue_ready, stall_raw, stall_waw, stall_port, busy_mask, wb_due
    );
endinterface

// File: rtl/grf_scoreboard.sv
// rtl/grf_scoreboard.sv - Per-register write-latency scoreboard gating issue on RAW/WAW/write-port hazards (optional SCB_TRACE_EN)
module grf_scoreboard #(
    parameter int NREG  = 32,
    parameter int CNT_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    grf_scoreboard_if.slave    sb
);
    localparam int RW     = $clog2(NREG);
    localparam int MAXLAT = (1 << CNT_W) - 1;

    logic [CNT_W-1:0] cnt [NREG];
    logic [MAXLAT:0]  sched;
    logic [MAXLAT:0]  sched_nxt;
    logic             tracked;
    logic             raw_a;
    logic             raw_b;
    logic             fire_trk;

    assign tracked = (sb.issue_dst != '0) && (sb.issue_lat != '0);

    // cnt == 1 lands this cycle and is covered by the GRF bypass, hence >= 2
    assign raw_a = sb.need_a && (sb.rs_a != '0) && (cnt[sb.rs_a] >= CNT_W'(2));
    assign raw_b = sb.need_b && (sb.rs_b != '0) && (cnt[sb.rs_b] >= CNT_W'(2));

    assign sb.stall_raw   = sb.issue_valid && (raw_a || raw_b);
    assign sb.stall_waw   = sb.issue_valid && tracked && (cnt[sb.issue_dst] > sb.issue_lat);
    assign sb.stall_port  = sb.issue_valid && tracked && sched[sb.issue_lat];
    assign sb.issue_ready = ~(sb.stall_raw | sb.stall_waw | sb.stall_port);
    assign sb.wb_due      = sched[0];

    assign fire_trk = sb.issue_valid && sb.issue_ready && tracked;

    always_comb begin
        sb.busy_mask = '0;
        for (int r = 1; r < NREG; r++) begin
            sb.busy_mask[r] = (cnt[r] != '0);
        end
    end

    always_comb begin
        sched_nxt = sched >> 1;
        if (fire_trk) begin
            sched_nxt[sb.issue_lat - CNT_W'(1)] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
            sched <= '0;
        end else begin
            cnt[0] <= '0;
            for (int r = 1; r < NREG; r++) begin
                if (fire_trk && (sb.issue_dst == RW'(r))) begin
                    cnt[r] <= sb.issue_lat;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - CNT_W'(1);
                end
            end
            sched <= sched_nxt;
        end
    end

`ifdef SCB_TRACE_EN
    always @(posedge clk) begin
        if (reset) begin
            if (fire_trk) begin
                $display("%d@scb: $%d lat %d", $time, sb.issue_dst, sb.issue_lat);
            end
            if (sb.issue_valid && !sb.issue_ready) begin
                $display("%d@scb: stall raw %b waw %b port %b", $time,
                         sb.stall_raw, sb.stall_waw, sb.stall_port);
            end
        end
    end
`endif

endmodule

// File: tb/tb_grf_scoreboard.sv
// tb/tb_grf_scoreboard.sv - Directed self-checking bench for grf_scoreboard
module tb_grf_scoreboard;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    grf_scoreboard_if #(.NREG(32), .CNT_W(3)) sb_if ();

    grf_scoreboard #(.NREG(32), .CNT_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] dst, input logic [2:0] lat,
                         input logic na, input logic [4:0] ra,
                         input logic nb, input logic [4:0] rb);
        sb_if.issue_valid = v;
        sb_if.issue_dst   = dst;
        sb_if.issue_lat   = lat;
        sb_if.need_a      = na;
        sb_if.rs_a        = ra;
        sb_if.need_b      = nb;
        sb_if.rs_b        = rb;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b1, 5'd5, 3'd3, 1'b0, 5'd0, 1'b0, 5'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (sb_if.busy_mask !== 32'h0 || sb_if.wb_due !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cyc %0d busy=%h wb_due=%b want 0/0", i, sb_if.busy_mask, sb_if.wb_due);
            end
            checks++;
            if (sb_if.issue_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_ready cyc %0d got %b want 1", i, sb_if.issue_ready);
            end
        end
        drive(1'b0, 5'd0, 3'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (sb_if.busy_mask !== 32'h0 || sb_if.wb_due !== 1'b0) begin
            errors++;
            $display("FAIL reset_release busy=%h wb_due=%b want 0/0", sb_if.busy_mask, sb_if.wb_due);
        end
    endtask

    task automatic test_raw();
        drive(1'b1, 5'd8, 3'd3, 1'b0, 5'd0, 1'b0, 5'd0);
        checks++;
        if (sb_if.issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL raw_issue ready got %b want 1", sb_if.issue_ready);
        end
        tick();
        drive(1'b1, 5'd0, 3'd0, 1'b1, 5'd8, 1'b0, 5'd0);
        for (int k = 1; k <= 3; k++) begin
            checks++;
            if (sb_if.stall_raw !== (k < 3)) begin
                errors++;
                $display("FAIL raw_stall t+%0d got %b want %b", k, sb_if.stall_raw, (k < 3));
            end
            checks++;
            if (sb_if.wb_due !== (k == 3)) begin
                errors++;
                $display("FAIL raw_wb_due t+%0d got %b want %b", k, sb_if.wb_due, (k == 3));
            end
            checks++;
            if (sb_if.busy_mask[8] !== 1'b1) begin
                errors++;
                $display("FAIL raw_busy t+%0d got %b want 1", k, sb_if.busy_mask[8]);
            end
            tick();
        end
        drive(1'b0, 5'd0, 3'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        checks++;
        if (sb_if.busy_mask !== 32'h0 || sb_if.wb_due !== 1'b0) begin
            errors++;
            $display("FAIL raw_clear busy=%h wb_due=%b want 0/0", sb_if.busy_mask, sb_if.wb_due);
        end
    endtask

    task automatic test_port();
        drive(1'b1, 5'd4, 3'd4, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        drive(1'b1, 5'd6, 3'd3, 1'b0, 5'd0, 1'b0, 5'd0);
        checks++;
        if (sb_if.stall_port !== 1'b1 || sb_if.issue_ready !== 1'b0) begin
            errors++;
            $display("FAIL port_conflict port=%b ready=%b want 1/0", sb_if.stall_port, sb_if.issue_ready);
        end
        drive(1'b1, 5'd6, 3'd2, 1'b0, 5'd0, 1'b0, 5'd0);
        checks++;
        if (sb_if.stall_port !== 1'b0 || sb_if.issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL port_free port=%b ready=%b want 0/1", sb_if.stall_port, sb_if.issue_ready);
        end
        tick();
        drive(1'b0, 5'd0, 3'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        // r6 lands two cycles after its issue, r4 one cycle later
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (sb_if.wb_due !== (k == 1 || k == 2)) begin
                errors++;
                $display("FAIL port_wb_due step %0d got %b want %b", k, sb_if.wb_due, (k == 1 || k == 2));
            end
            tick();
        end
        checks++;
        if (sb_if.busy_mask !== 32'h0) begin
            errors++;
            $display("FAIL port_clear busy=%h want 0", sb_if.busy_mask);
        end
    endtask

    task automatic test_waw();
        drive(1'b1, 5'd9, 3'd6, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        drive(1'b1, 5'd9, 3'd2, 1'b0, 5'd0, 1'b0, 5'd0);
        checks++;
        if (sb_if.stall_waw !== 1'b1 || sb_if.stall_port !== 1'b0 || sb_if.issue_ready !== 1'b0) begin
            errors++;
            $display("FAIL waw_stall waw=%b port=%b ready=%b want 1/0/0",
                     sb_if.stall_waw, sb_if.stall_port, sb_if.issue_ready);
        end
        tick();
        drive(1'b1, 5'd9, 3'd6, 1'b0, 5'd0, 1'b0, 5'd0);
        checks++;
        if (sb_if.stall_waw !== 1'b0 || sb_if.issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL waw_accept waw=%b ready=%b want 0/1", sb_if.stall_waw, sb_if.issue_ready);
        end
        tick();
        drive(1'b0, 5'd0, 3'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        for (int k = 3; k <= 9; k++) begin
            checks++;
            if (sb_if.busy_mask[9] !== (k <= 8) || sb_if.wb_due !== (k == 6 || k == 8)) begin
                errors++;
                $display("FAIL waw_track c%0d busy9=%b wb_due=%b want %b/%b", k,
                         sb_if.busy_mask[9], sb_if.wb_due, (k <= 8), (k == 6 || k == 8));
            end
            tick();
        end
    endtask

    task automatic test_src_dst();
        drive(1'b1, 5'd10, 3'd2, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        drive(1'b1, 5'd10, 3'd5, 1'b0, 5'd0, 1'b1, 5'd10);
        checks++;
        if (sb_if.stall_raw !== 1'b1) begin
            errors++;
            $display("FAIL srcdst_raw got %b want 1", sb_if.stall_raw);
        end
        tick();
        checks++;
        if (sb_if.issue_ready !== 1'b1 || sb_if.wb_due !== 1'b1) begin
            errors++;
            $display("FAIL srcdst_cnt1 ready=%b wb_due=%b want 1/1", sb_if.issue_ready, sb_if.wb_due);
        end
        tick();
        drive(1'b0, 5'd0, 3'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        checks++;
        if (sb_if.busy_mask[10] !== 1'b1 || sb_if.wb_due !== 1'b0) begin
            errors++;
            $display("FAIL srcdst_reissue busy10=%b wb_due=%b want 1/0", sb_if.busy_mask[10], sb_if.wb_due);
        end
        for (int k = 0; k < 5; k++) tick();
        checks++;
        if (sb_if.busy_mask !== 32'h0) begin
            errors++;
            $display("FAIL srcdst_clear busy=%h want 0", sb_if.busy_mask);
        end
    endtask

    task automatic test_zero();
        drive(1'b1, 5'd0, 3'd5, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        drive(1'b1, 5'd7, 3'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        drive(1'b1, 5'd0, 3'd0, 1'b1, 5'd0, 1'b1, 5'd0);
        checks++;
        if (sb_if.busy_mask !== 32'h0 || sb_if.wb_due !== 1'b0) begin
            errors++;
            $display("FAIL zero_busy busy=%h wb_due=%b want 0/0", sb_if.busy_mask, sb_if.wb_due);
        end
        checks++;
        if (sb_if.stall_raw !== 1'b0 || sb_if.issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_rs0 raw=%b ready=%b want 0/1", sb_if.stall_raw, sb_if.issue_ready);
        end
        drive(1'b1, 5'd0, 3'd0, 1'b1, 5'd7, 1'b0, 5'd0);
        checks++;
        if (sb_if.stall_raw !== 1'b0 || sb_if.issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_rs7 raw=%b ready=%b want 0/1", sb_if.stall_raw, sb_if.issue_ready);
        end
        tick();
        drive(1'b0, 5'd0, 3'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    endtask

    task automatic test_async_reset();
        drive(1'b1, 5'd3, 3'd7, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        drive(1'b1, 5'd11, 3'd2, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 3'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        checks++;
        if (sb_if.busy_mask[3] !== 1'b1 || sb_if.wb_due !== 1'b1) begin
            errors++;
            $display("FAIL async_pre busy3=%b wb_due=%b want 1/1", sb_if.busy_mask[3], sb_if.wb_due);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (sb_if.busy_mask !== 32'h0 || sb_if.wb_due !== 1'b0) begin
            errors++;
            $display("FAIL async_drop busy=%h wb_due=%b want 0/0", sb_if.busy_mask, sb_if.wb_due);
        end
        tick();
        reset = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        checks++;
        if (sb_if.busy_mask !== 32'h0 || sb_if.wb_due !== 1'b0) begin
            errors++;
            $display("FAIL async_after busy=%h wb_due=%b want 0/0", sb_if.busy_mask, sb_if.wb_due);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        drive(1'b0, 5'd0, 3'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        test_reset();
        test_raw();
        test_port();
        test_waw();
        test_src_dst();
        test_zero();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
